// File: rtl/fifo_wr_arbiter.sv
// Two-producer write arbiter and pointer controller for a 2**ADDR_W entry FIFO.
// Round-robin write grants, guarded read acknowledge, and a FLUSH state that drains the FIFO.
module fifo_wr_arbiter #(
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              rd_req,
  output logic              rd_ack,
  input  logic              flush,
  output logic              wen,
  output logic              ren,
  output logic [ADDR_W:0]   wrAddress,
  output logic [ADDR_W:0]   rdAddress,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy
);

  // state | meaning
  // RUN   | normal arbitration, writes and reads allowed
  // FLUSH | no grants or acks; one entry drained per cycle until empty
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            wr_elig;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      prio_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Flags come from the pre-edge pointers, so a read from full frees space only next cycle.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign busy  = (state_q == FLUSH);

  assign wrAddress = wr_ptr_q;
  assign rdAddress = rd_ptr_q;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rd_ack   = 1'b0;
    ren      = 1'b0;
    wr_elig  = (state_q == RUN) && !full;

    // prio_q = 0 favours req0 on a tie, 1 favours req1.
    if (wr_elig) begin
      gnt0 = req0 && (!req1 || !prio_q);
      gnt1 = req1 && (!req0 || prio_q);
    end
    wen = gnt0 | gnt1;

    if (gnt0)      prio_d = 1'b1;
    else if (gnt1) prio_d = 1'b0;

    rd_ack = rd_req && !empty && (state_q == RUN);
    ren    = rd_ack || ((state_q == FLUSH) && !empty);

    if (wen) wr_ptr_d = wr_ptr_q + 1'b1;
    if (ren) rd_ptr_d = rd_ptr_q + 1'b1;

    case (state_q)
      RUN:     if (flush && !empty) state_d = FLUSH;
      FLUSH:   if (empty)           state_d = RUN;
      default:                      state_d = RUN;
    endcase
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 3, FIFO address width; depth = 2**ADDR_W (8 entries by default).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req0, req1  input  1 each  write requests from producers 0 and 1.
REQ-005 Port: gnt0, gnt1  output  1 each  combinational write grants; a write occurs in a cycle with a grant.
REQ-006 Port: rd_req  input  1  consumer read request.
REQ-007 Port: rd_ack  output  1  combinational read acknowledge; a read occurs in a cycle with rd_ack.
REQ-008 Port: flush  input  1  single-cycle pulse that starts a drain.
REQ-009 Port: wen, ren  output  1 each  guarded write and read strobes to the FIFO storage.
REQ-010 Port: wrAddress, rdAddress  output  ADDR_W+1 each  registered pointers; the MSB is the wrap bit and the low ADDR_W bits are the storage address.
REQ-011 Port: full, empty  output  1 each  combinational status flags decoded from the pointers.
REQ-012 Port: count  output  ADDR_W+1  occupancy, range 0..2**ADDR_W.
REQ-013 Port: busy  output  1  high while in FLUSH.

Function
REQ-014 Occupancy: count SHALL equal (wrAddress - rdAddress) modulo 2**(ADDR_W+1).
REQ-015 Flags: empty SHALL be high when the pointers are equal; full SHALL be high when the low ADDR_W bits are equal and the MSBs differ.
REQ-016 States: the FSM SHALL have two states, RUN and FLUSH; busy = (state == FLUSH).
REQ-017 Write eligibility: a write SHALL be eligible only when state == RUN and full == 0.
REQ-018 Single requester: if eligible and exactly one of req0/req1 is high, that requester SHALL be granted.
REQ-019 Both requesters: if eligible and both are high, the grant SHALL go to the requester selected by a 1-bit round-robin priority register.
  - After reset the priority register SHALL favour req0.
  - After any grant, priority SHALL move to the non-granted requester.
  - With no grant, priority SHALL hold.
REQ-020 Grant exclusivity: at most one of gnt0/gnt1 SHALL be high, and wen = gnt0 | gnt1.
REQ-021 Read acknowledge: rd_ack SHALL equal rd_req & ~empty & (state == RUN).
REQ-022 Read strobe: ren = rd_ack | (state == FLUSH & ~empty).
REQ-023 Pointer update: on each clock edge, wrAddress SHALL increment by 1 if wen is high and rdAddress SHALL increment by 1 if ren is high, both wrapping modulo 2**(ADDR_W+1).
REQ-024 Same-cycle read/write: a write and a read in the same cycle SHALL both take effect, leaving count unchanged.
  - When full, the read SHALL be allowed and the write SHALL be refused, because flags are evaluated from pre-edge pointers.
  - When empty, the read SHALL be refused.
REQ-025 RUN -> FLUSH: from RUN, flush high with empty == 0 SHALL move the FSM to FLUSH at the next edge.
  - flush high with empty == 1 SHALL be ignored.
  - Writes and reads SHALL still follow REQ-018 to REQ-021 in the cycle flush is sampled.
REQ-026 FLUSH behaviour: in FLUSH, no grants and no rd_ack SHALL be issued, and one entry SHALL be drained per cycle.
  - When empty == 1 is sampled in FLUSH, the FSM SHALL return to RUN at that edge.
  - flush pulses received in FLUSH SHALL be ignored.
REQ-027 Flush latency: draining N entries SHALL take N cycles in FLUSH plus 1 cycle to exit; RUN resumes on cycle N+2 after the flush pulse.
REQ-028 Overflow/underflow: the pointers SHALL never overflow or underflow for any input sequence.

Reset
REQ-029 Reset values: while reset_n is low, the block SHALL force wrAddress = 0, rdAddress = 0, state = RUN, and priority = req0, asynchronously.
REQ-030 Outputs under reset: as a result, empty = 1, full = 0, count = 0, busy = 0; gnt0, gnt1, wen, ren and rd_ack = 0 unless a request is present (writes are eligible in RUN).
REQ-031 Reset mid-operation: assertion of reset_n mid-operation, including during FLUSH, SHALL abort the operation immediately, and FIFO contents SHALL be treated as discarded.
REQ-032 Reset release: reset_n deassertion SHALL be synchronous to the clock by external means; no internal synchronizer is required.

Verification
REQ-033 Fill: req0 held high for 10 cycles from reset -> 8 grants, full = 1, count = 8, wrAddress = 8 (4'b1000), gnt0 = 0 on cycles 9-10.
REQ-034 Fairness: req0 and req1 both held high from reset, rd_req held high -> grants alternate gnt0, gnt1, gnt0, gnt1, ...; first grant goes to gnt0.
REQ-035 Full with simultaneous requests: FIFO full, req1 and rd_req high -> rd_ack = 1, gnt1 = 0, count = 7 next cycle; following cycle gnt1 = 1.
REQ-036 Empty read: after reset, rd_req high with no writes -> rd_ack = 0, ren = 0, rdAddress stays 0.
REQ-037 Flush: count = 5, flush pulsed, req0 and rd_req held high -> busy high for 6 cycles, ren high for 5 of them, no grants or rd_ack while busy, count = 0, then gnt0 resumes.
REQ-038 Wrap and reset: 20 writes interleaved with reads -> pointers wrap 15 -> 0 with correct full/empty; reset_n pulsed low during FLUSH -> pointers = 0, busy = 0 immediately.
